muldiv_iter: RTL and testbench
==============================

// Module: muldiv_iter
// PURPOSE
//  Parametrised iterative RV64M multiply/divide unit for the execute stage; successor to the single-mode mul.
//  Covers all eight M ops plus W variants, with MUL_BITS product bits retired per cycle (multiply)
//  and 1 quotient bit per cycle (divide). Uses a valid/ready handshake on both sides and supports flush.
//  Execute stalls on busy and consumes the result when out_valid is high.
// PARAMETERS
//  XLEN      64  operand/result width (32 or 64)
//  MUL_BITS  2   multiplier bits per cycle; power of 2, divides 32
// PORTS
//  clk        in   1     clock; all state on posedge
//  reset      in   1     synchronous, active-high
//  flush      in   1     kill in-flight op (branch mispredict/trap)
//  in_valid   in   1     operation request
//  in_ready   out  1     unit can accept (state IDLE)
//  funct3     in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  is_word    in   1     W variant: use a[31:0], b[31:0]; sign-extend 32-bit result
//  a, b       in   XLEN  rs1, rs2 (already forwarded)
//  out_valid  out  1     result valid; held until out_ready
//  out_ready  in   1     consumer takes result this cycle
//  result     out  XLEN  final result
//  busy       out  1     state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; out_valid=0; result=0; busy=0; in_ready=1.
//  Accept when in_valid & in_ready & !flush. Latch funct3, is_word, and operand magnitudes.
//  Latch the result sign: MUL*: sa^sb; DIV: sa^sb; REM: sa (dividend sign). Unsigned ops: signs 0.
//  W = is_word ? 32 : XLEN.
//  States:
//   IDLE -> MUL (funct3[2]=0) | DIV (funct3[2]=1) | DONE (div-special) on accept
//   MUL: W/MUL_BITS cycles. Shift-add of unsigned magnitudes into a 2W-bit accumulator.
//        Counter counts down to 0, then -> DONE.
//   DIV: W cycles. Restoring division, 1 bit/cycle. Counter counts down to 0, then -> DONE.
//   DONE: out_valid=1, result stable. out_ready -> IDLE. Holds otherwise.
//  Latency, accept edge = cycle 0: out_valid rises at cycle W/MUL_BITS+1 (mul), W+1 (div), 1 (special).
//  in_ready only in IDLE; no accept in the cycle out_valid is consumed.
//  Result selection (after 2's-complement sign fix of the magnitude result):
//   MUL low W bits; MULH/MULHSU/MULHU high W bits of the 2W product.
//   MULHSU: only a is signed. MULHU: neither operand is signed.
//   DIV/DIVU quotient; REM/REMU remainder.
//   is_word: result = sext(r[31:0]) to XLEN. MULH* with is_word is not a legal RV op; output is don't-care.
//  Special cases, resolved at accept and sent straight to DONE:
//   b==0:                    quotient = all-ones; remainder = a (truncated to W, then sext if word).
//   signed, a==MIN, b==-1:   quotient = a; remainder = 0.
//   Both rules use W-width values when is_word.
//  Flush: any state -> IDLE next cycle; out_valid=0; result is not updated.
//   flush and in_valid in the same cycle: no accept.
//   flush in DONE discards the result even if out_ready is high.
//  Reset mid-operation behaves like flush, plus result=0.
//  busy = (state != IDLE), including DONE.
//  No combinational path from in_* to out_*.
// TESTING
//  MUL a=7, b=-3, XLEN=64, MUL_BITS=2 -> result=-21; out_valid at cycle 33 after accept.
//  MULH a=0x8000_0000_0000_0000, b=2 -> result=0xFFFF_FFFF_FFFF_FFFF.
//  MULHU with the same operands -> result=1.
//  DIVW a=0x0000_0001_8000_0000, b=-1 -> overflow case: result=0xFFFF_FFFF_8000_0000; out_valid at cycle 1.
//  REM a=-7, b=2 -> result=-1; REMU a=5, b=0 -> result=5; DIVU a=5, b=0 -> result=all-ones.
//  Start DIV, assert flush at cycle 10 -> IDLE at cycle 11; out_valid never rises;
//   next MUL 3*4 -> 12.
//  Result held with out_ready=0 for 5 cycles -> out_valid and result stable, in_ready=0;
//   out_ready=1 -> IDLE next cycle.

Source files
------------

// File: rtl/muldiv_iter.sv
// Iterative RV64M mul/div: MUL_BITS product bits/cycle, 1 quotient bit/cycle; out_valid at W/MUL_BITS+1, W+1 or 1 (special).
// Single op in flight: in_ready only in IDLE, result held in DONE until out_ready; flush kills any state.
module muldiv_iter #(
  parameter int XLEN     = 64,
  parameter int MUL_BITS = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic            is_word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW  = $clog2(XLEN);
  localparam int XW2 = 2 * XLEN;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       f3_q, f3_d;
  logic             word_q, word_d;
  logic             neg_q, neg_d;
  // acc holds the product when multiplying and {remainder, quotient} when dividing
  logic [XW2-1:0]   acc_q, acc_d;
  logic [XW2-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]  mplier_q, mplier_d;
  logic [XLEN-1:0]  result_q, result_d;

  logic             a_signed, b_signed, sa, sb, div0, ovf;
  logic [XLEN-1:0]  a_ext, b_ext, a_mag, b_mag, spec_q, spec_r;
  logic [XW2-1:0]   partial, acc_n, prod_fix;
  logic [XLEN:0]    shifted;
  logic [XLEN+1:0]  diff;
  logic             qbit;
  logic [XLEN-1:0]  quo_n, rem_n, r_raw;

  function automatic logic [XLEN-1:0] wfix(input logic w, input logic [XLEN-1:0] v);
    return w ? XLEN'($signed(v[31:0])) : v;
  endfunction

  // Operand decode from the request port; only used on the accept edge.
  always_comb begin
    a_signed = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    b_signed = a_signed && (funct3 != 3'b010);
    a_ext = is_word ? (a_signed ? XLEN'($signed(a[31:0])) : XLEN'(a[31:0])) : a;
    b_ext = is_word ? (b_signed ? XLEN'($signed(b[31:0])) : XLEN'(b[31:0])) : b;
    sa    = a_signed & a_ext[XLEN-1];
    sb    = b_signed & b_ext[XLEN-1];
    a_mag = sa ? -a_ext : a_ext;
    b_mag = sb ? -b_ext : b_ext;
    div0  = is_word ? (b[31:0] == 32'h0) : (b == '0);
    ovf   = a_signed & (is_word ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                                : (a == {1'b1, {(XLEN-1){1'b0}}} && b == '1));
    spec_q = div0 ? '1 : wfix(is_word, a);
    spec_r = div0 ? wfix(is_word, a) : '0;
  end

  // One iteration step of each datapath, evaluated from the current state.
  always_comb begin
    partial = '0;
    for (int i = 0; i < MUL_BITS; i++) begin
      if (mplier_q[i]) partial = partial + (mcand_q << i);
    end
    acc_n    = acc_q + partial;
    prod_fix = neg_q ? -acc_n : acc_n;

    shifted = {acc_q[XW2-1:XLEN], acc_q[XLEN-1]};
    diff    = {1'b0, shifted} - {2'b00, mcand_q[XLEN-1:0]};
    qbit    = ~diff[XLEN+1];
    rem_n   = qbit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_n   = {acc_q[XLEN-2:0], qbit};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    word_d   = word_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    r_raw    = '0;
    case (state_q)
      S_IDLE: begin
        if (in_valid && !flush) begin
          f3_d     = funct3;
          word_d   = is_word;
          neg_d    = (funct3[2] && funct3[1]) ? sa : (sa ^ sb);
          mplier_d = b_mag;
          if (funct3[2]) begin
            mcand_d = XW2'(b_mag);
            acc_d   = XW2'(is_word ? (a_mag << (XLEN - 32)) : a_mag);
            cnt_d   = is_word ? CW'(31) : CW'(XLEN - 1);
          end else begin
            mcand_d = XW2'(a_mag);
            acc_d   = '0;
            cnt_d   = is_word ? CW'(32 / MUL_BITS - 1) : CW'(XLEN / MUL_BITS - 1);
          end
          if (funct3[2] && (div0 || ovf)) begin
            result_d = funct3[1] ? spec_r : spec_q;
            state_d  = S_DONE;
          end else begin
            state_d  = funct3[2] ? S_DIV : S_MUL;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_n;
        mcand_d  = mcand_q << MUL_BITS;
        mplier_d = mplier_q >> MUL_BITS;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          r_raw    = (f3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[XW2-1:XLEN];
          result_d = wfix(word_q, r_raw);
          state_d  = S_DONE;
        end
      end
      S_DIV: begin
        acc_d = {rem_n, quo_n};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          if (f3_q[1]) r_raw = neg_q ? -rem_n : rem_n;
          else         r_raw = neg_q ? -quo_n : quo_n;
          result_d = wfix(word_q, r_raw);
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A killed op must leave the previously delivered result untouched.
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      word_q   <= word_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter (XLEN=64, MUL_BITS=2): results, latency, flush, hold and reset.
module tb_muldiv_iter;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, is_word, out_valid, out_ready, busy;
  logic [2:0]  funct3;
  logic [63:0] a, b, result;
  int          errors = 0;
  int          checks = 0;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  muldiv_iter #(.XLEN(64), .MUL_BITS(2)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .is_word(is_word), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request; returns sampled #1 after the accept edge (cycle 1).
  task automatic issue(input logic [2:0] f3, input logic w, input logic [63:0] av, input logic [63:0] bv);
    int n = 0;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    funct3 = f3; is_word = w; a = av; b = bv; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      step();
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] f3, input logic w,
                       input logic [63:0] av, input logic [63:0] bv,
                       input logic [63:0] exp, input int exp_lat);
    int lat;
    issue(f3, w, av, bv);
    wait_valid(lat);
    chk({tag, "_vld"}, 64'(out_valid), 64'd1);
    chk({tag, "_res"}, result, exp);
    if (exp_lat > 0) chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    int lat, seen;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    funct3 = '0; is_word = 1'b0; a = '0; b = '0;
    step(); step();
    reset = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", result, 64'd0);

    do_op("mul_7x-3", MUL, 1'b0, 64'd7, -64'sd3, -64'sd21, 33);
    do_op("mulh_min_2", MULH, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    do_op("mulhu_min_2", MULHU, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 64'd1, 33);
    do_op("mulhsu_-1_2", MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    do_op("mulw", MUL, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 17);
    do_op("divw_ovf", DIV, 1'b1, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'hFFFF_FFFF_8000_0000, 1);
    do_op("rem_-7_2", REM, 1'b0, -64'sd7, 64'd2, -64'sd1, 65);
    do_op("remu_5_0", REMU, 1'b0, 64'd5, 64'd0, 64'd5, 1);
    do_op("divu_5_0", DIVU, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    do_op("div_-20_3", DIV, 1'b0, -64'sd20, 64'd3, -64'sd6, 65);
    do_op("div_ovf", DIV, 1'b0, 64'h8000_0000_0000_0000, -64'sd1, 64'h8000_0000_0000_0000, 1);
    do_op("rem_ovf", REM, 1'b0, 64'h8000_0000_0000_0000, -64'sd1, 64'd0, 1);
    do_op("divuw", DIVU, 1'b1, 64'hFFFF_FFFF_0000_0010, 64'd3, 64'd5, 33);
    do_op("remw", REM, 1'b1, -64'sd7, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 33);

    // Flush mid-divide at cycle 10; previous result (remw) must survive.
    issue(DIV, 1'b0, 64'd100, 64'd7);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_busy", 64'(busy), 64'd0);
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      if (out_valid) seen++;
      step();
    end
    chk("flush_no_valid", 64'(seen), 64'd0);
    chk("flush_result_kept", result, 64'hFFFF_FFFF_FFFF_FFFF);
    do_op("mul_after_flush", MUL, 1'b0, 64'd3, 64'd4, 64'd12, 33);

    // Flush together with in_valid: nothing accepted.
    funct3 = MUL; is_word = 1'b0; a = 64'd9; b = 64'd9; in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_vs_req_busy", 64'(busy), 64'd0);

    // Hold in DONE for 5 cycles, then consume.
    issue(MUL, 1'b0, 64'd6, 64'd7);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      chk("hold_vld", 64'(out_valid), 64'd1);
      chk("hold_res", result, 64'd42);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("consume_in_ready", 64'(in_ready), 64'd1);
    chk("consume_vld", 64'(out_valid), 64'd0);

    // Flush in DONE with out_ready high discards; result register unchanged.
    issue(DIVU, 1'b0, 64'd50, 64'd5);
    wait_valid(lat);
    chk("done_flush_pre", result, 64'd10);
    out_ready = 1'b1; flush = 1'b1;
    step();
    out_ready = 1'b0; flush = 1'b0;
    chk("done_flush_vld", 64'(out_valid), 64'd0);
    chk("done_flush_res", result, 64'd10);

    // Reset mid-operation clears result.
    issue(MUL, 1'b0, 64'd5, 64'd5);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_result", result, 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_vld", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
